regfile_mp: RTL and testbench

Parametrised multi-port register file for the RISKY core, superseding the single-write, two-read register file. It provides a configurable number of combinational read ports and two write ports, with x0 hardwired to zero. After reset, a hardware clear sequencer zeroes every register. The block sits between decode (read addresses) and writeback (write ports) and signals readiness to the pipeline controller.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_mp_clear.sv | 60 ++++++
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    // Clear sequencer states.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Supported range of read ports.
    localparam int NREAD_MIN = 1;
    localparam int NREAD_MAX = 4;

    // Hardwired-zero register index.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_mp_clear.sv
// Post-reset clear sequencer: walks indices 1..REGISTERS-1, issuing one
// zeroing write per cycle, then signals ready.
module regfile_mp_clear
    import regfile_pkg::*;
#(
    parameter int REGISTERS = 32,
    parameter int INDEX     = $clog2(REGISTERS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             clear_we,
    output logic [INDEX-1:0] clear_addr,
    output logic             ready
);

    localparam logic [INDEX-1:0] LAST_ADDR = INDEX'(REGISTERS - 1);

    state_e           state_q, state_d;
    logic [INDEX-1:0] cnt_q,   cnt_d;

    // State register and clear counter with synchronous reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= INDEX'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter advance and sequencer outputs.
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clear_we   = 1'b0;
        clear_addr = cnt_q;
        ready      = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_we = 1'b1;
                cnt_d    = cnt_q + INDEX'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                ready = 1'b1;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NREAD combinational read ports,
// x0 hardwired to zero, hardware clear after reset.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle write
// data to matching read lanes (port 1 has priority).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int REGISTERS = 32,
    parameter int NREAD     = 2,
    parameter int INDEX     = $clog2(REGISTERS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we0,
    input  logic [INDEX-1:0]          wa0,
    input  logic [DATAWIDTH-1:0]      wd0,
    input  logic                      we1,
    input  logic [INDEX-1:0]          wa1,
    input  logic [DATAWIDTH-1:0]      wd1,
    input  logic [NREAD*INDEX-1:0]    ra,
    output logic [NREAD*DATAWIDTH-1:0] rd,
    output logic                      ready,
    output logic                      wcollide
);

    localparam logic [INDEX-1:0] ZERO_ADDR = INDEX'(ZERO_REG);

    logic [DATAWIDTH-1:0] mem_q [REGISTERS];
    logic [DATAWIDTH-1:0] mem_d [REGISTERS];
    logic                 wcollide_q, wcollide_d;
    logic                 clear_we;
    logic [INDEX-1:0]     clear_addr;

    regfile_mp_clear #(
        .REGISTERS (REGISTERS),
        .INDEX     (INDEX)
    ) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .ready      (ready)
    );

    // Next register contents: clear writes own the array until ready;
    // afterwards port 1 is applied last so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (clear_we) begin
            mem_d[clear_addr] = '0;
        end else begin
            if (we0 && wa0 != ZERO_ADDR) mem_d[wa0] = wd0;
            if (we1 && wa1 != ZERO_ADDR) mem_d[wa1] = wd1;
        end
        mem_d[ZERO_REG] = '0;
        wcollide_d = ready && we0 && we1 && (wa0 == wa1) && (wa0 != ZERO_ADDR);
    end

    // Register array update; frozen while reset is asserted so writes in the
    // reset cycle are dropped.
    // NOTE: the array has no reset branch on purpose; the clear sequencer
    // zeroes it, letting the storage map to plain flops/RAM without reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mem_q <= mem_d;
        end
    end

    // Collision pulse register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcollide_q <= 1'b0;
        end else begin
            wcollide_q <= wcollide_d;
        end
    end

    assign wcollide = wcollide_q;

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [INDEX-1:0]     lane_addr;
        logic [DATAWIDTH-1:0] lane_data;

        assign lane_addr = ra[k*INDEX +: INDEX];

        // Lane read mux: stored value, optional forwarding, zero for x0/CLEAR.
        always_comb begin
            lane_data = mem_q[lane_addr];
`ifdef REGFILE_MP_BYPASS_EN
            if (we1 && wa1 == lane_addr) begin
                lane_data = wd1;
            end else if (we0 && wa0 == lane_addr) begin
                lane_data = wd0;
            end
`else
`endif
            if (!ready || lane_addr == ZERO_ADDR) begin
                lane_data = '0;
            end
        end

        assign rd[k*DATAWIDTH +: DATAWIDTH] = lane_data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (4 read ports, defaults otherwise).
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 4;
    localparam int IW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                we0, we1;
    logic [IW-1:0]       wa0, wa1;
    logic [DW-1:0]       wd0, wd1;
    logic [NRD*IW-1:0]   ra;
    logic [NRD*DW-1:0]   rd;
    logic                ready;
    logic                wcollide;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp #(
        .DATAWIDTH (DW),
        .REGISTERS (NREG),
        .NREAD     (NRD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .ra       (ra),
        .rd       (rd),
        .ready    (ready),
        .wcollide (wcollide)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int lane, input logic [IW-1:0] addr);
        ra[lane*IW +: IW] = addr;
    endtask

    function automatic logic [DW-1:0] lane(input int k);
        return rd[k*DW +: DW];
    endfunction

    task automatic idle_writes();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
    endtask

    // Count edges after release until ready; optionally check rd lanes are 0.
    task automatic wait_ready(input string tag, output int edges);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < NRD; k++) set_ra(k, IW'((i % 8) * 4 + k));
            tick();
            edges++;
            if (ready) break;
            for (int k = 0; k < NRD; k++) check($sformatf("%s_rd%0d_c%0d", tag, k, edges), lane(k), '0);
        end
    endtask

    int edges;

    initial begin
        rst_n = 1'b0;
        idle_writes();
        ra = '0;
        repeat (2) tick();
        check("rst_ready",    {31'b0, ready},    '0);
        check("rst_wcollide", {31'b0, wcollide}, '0);
        check("rst_rd",       rd[DW-1:0],        '0);

        // Release; present colliding writes to x4 throughout CLEAR.
        rst_n = 1'b1;
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000_FFFF;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h0000_FFFF;
        wait_ready("clr", edges);
        idle_writes();
        check("ready_latency", edges, 31);
        check("ready_high",    {31'b0, ready},    32'd1);
        check("clr_no_coll",   {31'b0, wcollide}, '0);
        set_ra(0, 5'd4);
        #1 check("x4_ignored", lane(0), '0);

        // Single write to x5, observed on lane 0.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
        set_ra(0, 5'd5);
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("x5_same_cycle", lane(0), 32'hDEAD_BEEF);
`else
        check("x5_same_cycle", lane(0), '0);
`endif
        tick();
        idle_writes();
        #1 check("x5_written", lane(0), 32'hDEAD_BEEF);

        // Write to x0 is discarded.
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1;
        tick();
        idle_writes();
        set_ra(1, 5'd0);
        #1 check("x0_zero", lane(1), '0);

        // Same-address collision on x7: port 1 wins, one-cycle pulse.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        tick();
        idle_writes();
        set_ra(2, 5'd7);
        #1;
        check("coll_pulse", {31'b0, wcollide}, 32'd1);
        check("coll_x7",    lane(2),           32'h22);
        tick();
        check("coll_drop",  {31'b0, wcollide}, '0);

        // Collision on x0 does not pulse.
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h33;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h44;
        tick();
        idle_writes();
        check("coll_x0_none", {31'b0, wcollide}, '0);

        // Dual writes to distinct registers.
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h0000_0100;
        we1 = 1'b1; wa1 = 5'd11; wd1 = 32'h0000_0200;
        tick();
        idle_writes();
        set_ra(0, 5'd10);
        set_ra(3, 5'd11);
        #1;
        check("dual_x10", lane(0), 32'h0000_0100);
        check("dual_x11", lane(3), 32'h0000_0200);
        check("dual_no_coll", {31'b0, wcollide}, '0);

        // Bypass behaviour on x9.
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_1234;
        tick();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5A5_A5A5;
        set_ra(1, 5'd9);
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("x9_same_cycle", lane(1), 32'hA5A5_A5A5);
`else
        check("x9_same_cycle", lane(1), 32'h0000_1234);
`endif
        tick();
        idle_writes();
        #1 check("x9_next_cycle", lane(1), 32'hA5A5_A5A5);

        // Preload x3, then reset mid-clear and verify a full restart.
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hCAFE_0003;
        tick();
        idle_writes();
        set_ra(0, 5'd3);
        #1 check("x3_preload", lane(0), 32'hCAFE_0003);
        rst_n = 1'b0;
        tick();
        check("rst2_ready", {31'b0, ready}, '0);
        check("rst2_rd",    lane(0),        '0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("mid_clear_ready", {31'b0, ready}, '0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_ready("clr2", edges);
        check("ready_latency2", edges, 31);
        set_ra(0, 5'd3);
        set_ra(1, 5'd5);
        #1;
        check("x3_cleared", lane(0), '0);
        check("x5_cleared", lane(1), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
